// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared definitions for the pipeline stage latches
//
// Purpose: default payload/control widths and the skid-buffer state
// encoding shared by every pipeline latch (ID/EX, EX/MEM, MEM/WB).
// Ports: none (package).

package pipe_pkg;

  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CTRL_W = 11;

  // The encoding doubles as the occupancy count; 2'd3 is never used.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    case (s)
      ST_MAIN: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_latch_skid.sv
// rtl/pipe_latch_skid.sv - two-entry skid-buffered pipeline latch
//
// Purpose: registered pipeline stage with a main (output) register and one
// skid register so o_ready depends only on local state, never on i_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_flush           discard held beats and the incoming beat
//   i_valid/o_ready   upstream handshake, i_data/i_ctrl payload
//   o_valid/i_ready   downstream handshake, o_data/o_ctrl payload
//   o_occupancy       held beats (0..2)

module pipe_latch_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W              = PIPE_DATA_W,
  parameter int CTRL_W              = PIPE_CTRL_W,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (i_valid) begin
          load_main_in = 1'b1;
          state_d      = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (i_valid && i_ready) begin
          load_main_in = 1'b1;
        end else if (i_valid) begin
          load_skid = 1'b1;
          state_d   = ST_SKID;
        end else if (i_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // o_ready is low here, so i_valid carries no accepted beat.
        if (i_ready) begin
          load_main_skid = 1'b1;
          state_d        = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides every handshake in the same cycle.
    if (i_flush) begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      state_d        = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_data_q <= i_data;
        main_ctrl_q <= i_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= i_data;
        skid_ctrl_q <= i_ctrl;
      end
    end
  end

  assign o_ready     = (state_q != ST_SKID);
  assign o_valid     = (state_q == ST_MAIN) || (state_q == ST_SKID);
  assign o_occupancy = state_occupancy(state_q);
  assign o_data      = main_data_q;
  // Bubbles carry no control so downstream stages never see stale writes.
  assign o_ctrl      = (ZERO_CTRL_ON_BUBBLE && !o_valid) ? '0 : main_ctrl_q;

endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb/tb_pipe_latch_skid.sv - directed and random bench for pipe_latch_skid

module tb_pipe_latch_skid;
  import pipe_pkg::*;

  localparam int DW = PIPE_DATA_W;
  localparam int CW = PIPE_CTRL_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occupancy;

  int checks = 0;
  int errors = 0;

  pipe_latch_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ctrl(o_ctrl), .o_occupancy(o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input int val);
    i_valid = v;
    i_data  = DW'(val);
    i_ctrl  = CW'(val);
  endtask

  task automatic chk_state(input string name, input logic ev, input int ed,
                           input int ec, input int eocc, input logic erdy);
    checks++;
    if (o_valid !== ev || o_data !== DW'(ed) || o_ctrl !== CW'(ec) ||
        o_occupancy !== 2'(eocc) || o_ready !== erdy) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%0h c=%0h occ=%0d rdy=%0b, want v=%0b d=%0h c=%0h occ=%0d rdy=%0b",
               name, o_valid, o_data, o_ctrl, o_occupancy, o_ready, ev, ed, ec, eocc, erdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
    send(1'b1, 'h55);
    step();
    step();
    chk_state("reset", 1'b0, 0, 0, 0, 1'b1);
    rst = 1'b0;
    send(1'b0, 0);
    step();
    chk_state("post_reset_idle", 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_streaming();
    i_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, k);
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready beat %0d: got %0b want 1", k, o_ready);
      end
      step();
      chk_state($sformatf("stream_beat_%0d", k), 1'b1, k, k, 1, 1'b1);
    end
    send(1'b0, 0);
    step();
    chk_state("stream_drain", 1'b0, 5, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    send(1'b1, 'hA);
    step();
    chk_state("bp_first", 1'b1, 'hA, 'hA, 1, 1'b1);
    send(1'b1, 'hB);
    step();
    chk_state("bp_skid", 1'b1, 'hA, 'hA, 2, 1'b0);
    send(1'b1, 'hE);  // ignored: o_ready is low
    step();
    chk_state("bp_hold", 1'b1, 'hA, 'hA, 2, 1'b0);
    send(1'b0, 0);
    i_ready = 1'b1;
    step();
    chk_state("bp_release_b", 1'b1, 'hB, 'hB, 1, 1'b1);
    step();
    chk_state("bp_empty", 1'b0, 'hB, 0, 0, 1'b1);
  endtask

  task automatic test_flush_skid();
    i_ready = 1'b0;
    send(1'b1, 'hA);
    step();
    send(1'b1, 'hB);
    step();
    chk_state("flush_pre", 1'b1, 'hA, 'hA, 2, 1'b0);
    i_flush = 1'b1;
    send(1'b1, 'hC);
    step();
    chk_state("flush_skid", 1'b0, 'hA, 0, 0, 1'b1);
    i_flush = 1'b0;
    send(1'b0, 0);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_emit cycle %0d: got o_valid=%0b data=%0h want 0", k, o_valid, o_data);
      end
    end
    // Flush from MAIN with an acceptable incoming beat also drops it.
    send(1'b1, 'h3);
    step();
    i_flush = 1'b1;
    send(1'b1, 'h4);
    step();
    i_flush = 1'b0;
    send(1'b0, 0);
    chk_state("flush_main", 1'b0, 'h3, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    send(1'b1, 'hA);
    step();
    send(1'b1, 'hB);
    step();
    chk_state("rstmid_pre", 1'b1, 'hA, 'hA, 2, 1'b0);
    rst = 1'b1;
    i_ready = 1'b1;
    i_flush = 1'b1;
    send(1'b1, 'h9);
    step();
    chk_state("rstmid_reset", 1'b0, 0, 0, 0, 1'b1);
    rst = 1'b0;
    i_flush = 1'b0;
    send(1'b1, 'h7);
    step();
    chk_state("rstmid_beat7", 1'b1, 'h7, 'h7, 1, 1'b1);
    send(1'b0, 0);
    step();
    chk_state("rstmid_empty", 1'b0, 'h7, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    int sent = 0;
    int recv = 0;
    int local_err = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      i_valid = ($urandom_range(0, 99) < 60);
      i_ready = ($urandom_range(0, 99) < 50);
      i_data  = {$urandom, $urandom, $urandom};
      i_ctrl  = i_data[CW-1:0] ^ CW'('h5A5);
      if (o_occupancy === 2'd3 || o_occupancy !== 2'(q.size()) ||
          o_valid !== (q.size() != 0)) begin
        local_err++;
        if (local_err < 10)
          $display("FAIL rand_occ cycle %0d: got occ=%0d v=%0b want occ=%0d", cyc, o_occupancy, o_valid, q.size());
      end
      if (!o_valid && o_ctrl !== '0) begin
        local_err++;
        if (local_err < 10) $display("FAIL rand_bubble_ctrl cycle %0d: got %0h want 0", cyc, o_ctrl);
      end
      if (o_valid && i_ready && q.size() != 0) begin
        exp_d = q.pop_front();
        recv++;
        if (o_data !== exp_d || o_ctrl !== (exp_d[CW-1:0] ^ CW'('h5A5))) begin
          local_err++;
          if (local_err < 10)
            $display("FAIL rand_order cycle %0d: got d=%0h c=%0h want d=%0h", cyc, o_data, o_ctrl, exp_d);
        end
      end
      if (i_valid && o_ready) begin
        q.push_back(i_data);
        sent++;
      end
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (o_valid && q.size() != 0) begin
        exp_d = q.pop_front();
        recv++;
        if (o_data !== exp_d) begin
          local_err++;
          $display("FAIL rand_drain: got %0h want %0h", o_data, exp_d);
        end
      end
      step();
    end
    checks++;
    if (local_err != 0) begin
      errors++;
      $display("FAIL rand_run: %0d mismatching cycles, want 0", local_err);
    end
    checks++;
    if (recv != sent || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_count: got recv=%0d o_valid=%0b want recv=%0d o_valid=0", recv, o_valid, sent);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 96, which sets the width of the payload datapath (jump, pc_to_reg, ALU result, rt).
REQ-002 SHALL have parameter CTRL_W, default 11, which sets the width of the control bundle (write_pc, taken, RegWrite, MemWrite, MemRead, load/store type, ...).
REQ-003 SHALL have parameter ZERO_CTRL_ON_BUBBLE, default 1; when it is 1, o_ctrl is forced to zero whenever o_valid=0.
REQ-004 SHALL run on one clock, clk; reset rst is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_flush  in  1  discard all held and incoming beats
- i_valid  in  1  upstream beat present
- o_ready  out  1  upstream beat may be accepted this cycle
- i_data  in  DATA_W  upstream payload
- i_ctrl  in  CTRL_W  upstream control
- o_valid  out  1  downstream beat present
- i_ready  in  1  downstream accepts this cycle
- o_data  out  DATA_W  registered payload
- o_ctrl  out  CTRL_W  registered control
- o_occupancy  out  2  held beats (0..2)

Function
REQ-006 SHALL implement a 2-entry skid buffer: a main (output) register plus one skid register.
REQ-007 SHALL use a state machine with states EMPTY (occupancy 0), MAIN (occupancy 1), SKID (occupancy 2).
REQ-008 SHALL accept a beat when i_valid=1 and o_ready=1 (upstream handshake), and SHALL release a beat when o_valid=1 and i_ready=1 (downstream handshake).
REQ-009 SHALL drive o_ready=1 when state is not SKID, decoded from the state flop only; there SHALL be no combinational path from i_ready to o_ready.
REQ-010 SHALL drive o_valid=1 in the MAIN and SKID states.
REQ-011 SHALL have a latency of 1 cycle: a beat accepted in EMPTY appears on o_data/o_ctrl at the next edge.
REQ-012 SHALL make these transitions from EMPTY:
- i_valid: load main -> MAIN
- otherwise: stay EMPTY
REQ-013 SHALL make these transitions from MAIN:
- i_valid and i_ready: load main with the new beat, stay MAIN
- i_valid and not i_ready: load skid -> SKID
- not i_valid and i_ready: -> EMPTY
- otherwise: hold
REQ-014 SHALL make these transitions from SKID:
- i_ready: copy skid into main -> MAIN
- otherwise: hold
- i_valid SHALL be ignored in this state.
REQ-015 SHALL preserve beat order, with no loss and no duplication, under any i_valid/i_ready pattern.
REQ-016 SHALL, on i_flush=1, go to EMPTY at the next edge and discard the incoming beat even if o_ready=1; flush dominates all other events in that cycle.
REQ-017 SHALL, when ZERO_CTRL_ON_BUBBLE=1 and o_valid=0, drive o_ctrl to all-zero; o_data holds its last value.
REQ-018 SHALL hold the output registers stable while o_valid=1 and i_ready=0.
REQ-019 SHALL drive o_occupancy from the state flop: EMPTY=0, MAIN=1, SKID=2; the encoding 3 is never produced.

Reset
REQ-020 SHALL, with rst=1 at a clk edge, set state=EMPTY, o_valid=0, o_data=0, o_ctrl=0, skid registers=0, o_occupancy=0.
REQ-021 SHALL have o_ready=1 from the first edge after reset; inputs in a reset cycle are discarded.
REQ-022 SHALL give reset priority over flush and over both handshakes, including reset asserted mid-transfer while in SKID.

Structure
REQ-023 SHALL take the state encoding constants (EMPTY/MAIN/SKID) and the default DATA_W/CTRL_W from shared package pipe_pkg, reused by all pipeline latches.
REQ-024 SHALL be a single module with no sub-module; EX/MEM, ID/EX and MEM/WB latches are instances of it with different widths.

Verification
REQ-025 SHALL cover streaming: i_ready=1, beats 0x1..0x5 on consecutive cycles -> o_data 0x1..0x5, each 1 cycle later, o_ready constant 1.
REQ-026 SHALL cover backpressure: i_ready=0 while sending 0xA, then 0xB -> occupancy 1 then 2, o_ready=0, o_data=0xA held; release i_ready -> 0xA, then 0xB, no loss.
REQ-027 SHALL cover flush in SKID: hold 0xA/0xB, pulse i_flush with i_valid=1 (0xC) -> next cycle o_valid=0, o_ctrl=0, occupancy 0, 0xC never emitted.
REQ-028 SHALL cover reset mid-operation: rst=1 in SKID -> all outputs 0, o_ready=1 after the edge; the subsequent beat 0x7 emerges normally.
REQ-029 SHALL cover a randomized valid/ready run of 10k cycles against a scoreboard queue -> in-order, count-equal, o_occupancy never 3, o_ctrl=0 whenever o_valid=0.
